// File: rtl/map_ram_arbiter_if.sv
// Bundle of the three requester ports and the map bRAM port around map_ram_arbiter.
// slave = arbiter side, master = requesters plus bRAM model side.
interface map_ram_arbiter_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 16
);
   logic              req0, req1, req2;
   logic              we0, we1, we2;
   logic [ADDR_W-1:0] addr0, addr1, addr2;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              lock1;
   logic              ack0, ack1, ack2;
   logic              rvalid0, rvalid1, rvalid2;
   logic [DATA_W-1:0] rdata;
   logic              lock_err;
   logic [ADDR_W-1:0] bRAM_map_addr;
   logic              bRAM_map_wr;
   logic [DATA_W-1:0] bRAM_map_dwrite;
   logic [DATA_W-1:0] bRAM_map_data;

   // we2 never reaches the arbiter: the renderer port is read-only by construction.
   modport slave (
      input  req0, req1, req2, we0, we1, addr0, addr1, addr2, wdata0, wdata1, lock1,
      input  bRAM_map_data,
      output ack0, ack1, ack2, rvalid0, rvalid1, rvalid2, rdata, lock_err,
      output bRAM_map_addr, bRAM_map_wr, bRAM_map_dwrite
   );

   modport master (
      output req0, req1, req2, we0, we1, we2, addr0, addr1, addr2, wdata0, wdata1, lock1,
      output bRAM_map_data,
      input  ack0, ack1, ack2, rvalid0, rvalid1, rvalid2, rdata, lock_err,
      input  bRAM_map_addr, bRAM_map_wr, bRAM_map_dwrite
   );
endinterface

// File: rtl/map_ram_arbiter.sv
// Round-robin arbiter for the single map bRAM port with a port-1 exclusive lock
// for read-modify-write sequences; registered bRAM controls, 2-cycle read return.
module map_ram_arbiter #(
   parameter int ADDR_W       = 19,
   parameter int DATA_W       = 16,
   parameter int LOCK_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rstn,
   map_ram_arbiter_if.slave bus,
   output logic             dbg_lock_state_o
);
   localparam logic [0:0] ST_UNLOCKED = 1'b0;
   localparam logic [0:0] ST_LOCKED   = 1'b1;
   localparam int          CNT_W      = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT);

   // Handshake: reqN holds its command stable until ackN; ackN high means that
   // command went to the bRAM on the previous edge, and the requester may put
   // its next command on the port in that same ack cycle.
   logic [0:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              lock_err_q, lock_err_d;
   logic [1:0]        ptr_q;
   logic [2:0]        ack_q;
   logic [ADDR_W-1:0] addr_q;
   logic              wr_q;
   logic [DATA_W-1:0] dwrite_q;
   logic              tag1_vld_q, tag2_vld_q;
   logic [1:0]        tag1_port_q, tag2_port_q;

   logic              locked;
   logic [2:0]        elig;
   logic              sel_vld;
   logic [1:0]        sel_port;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_we;
   logic [DATA_W-1:0] sel_wdata;
   logic              gnt1;

   assign locked = (state_q == ST_LOCKED);
   // A port in its ack cycle is skipped, capping each port at one access per 2 cycles.
   assign elig[0] = bus.req0 & ~ack_q[0] & ~locked;
   assign elig[1] = bus.req1 & ~ack_q[1];
   assign elig[2] = bus.req2 & ~ack_q[2] & ~locked;

   always_comb begin
      sel_vld  = 1'b1;
      sel_port = 2'd0;
      case (ptr_q)
         2'd0: begin
            if      (elig[1]) sel_port = 2'd1;
            else if (elig[2]) sel_port = 2'd2;
            else if (elig[0]) sel_port = 2'd0;
            else              sel_vld  = 1'b0;
         end
         2'd1: begin
            if      (elig[2]) sel_port = 2'd2;
            else if (elig[0]) sel_port = 2'd0;
            else if (elig[1]) sel_port = 2'd1;
            else              sel_vld  = 1'b0;
         end
         default: begin
            if      (elig[0]) sel_port = 2'd0;
            else if (elig[1]) sel_port = 2'd1;
            else if (elig[2]) sel_port = 2'd2;
            else              sel_vld  = 1'b0;
         end
      endcase
   end

   always_comb begin
      sel_addr  = bus.addr0;
      sel_we    = bus.we0;
      sel_wdata = bus.wdata0;
      case (sel_port)
         2'd1: begin
            sel_addr  = bus.addr1;
            sel_we    = bus.we1;
            sel_wdata = bus.wdata1;
         end
         2'd2: begin
            sel_addr  = bus.addr2;
            sel_we    = 1'b0;
            sel_wdata = '0;
         end
         default: ;
      endcase
   end

   assign gnt1 = sel_vld && (sel_port == 2'd1);

   // A port-1 grant decides the lock outright; otherwise idle cycles run the timeout.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lock_err_d = 1'b0;
      if (gnt1) begin
         cnt_d   = '0;
         state_d = bus.lock1 ? ST_LOCKED : ST_UNLOCKED;
      end else if (locked && !bus.req1) begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
         if (cnt_d == CNT_MAX) begin
            state_d    = ST_UNLOCKED;
            lock_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_UNLOCKED;
         cnt_q      <= '0;
         lock_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lock_err_q <= lock_err_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr_q    <= 2'd2;
         ack_q    <= '0;
         addr_q   <= '0;
         wr_q     <= 1'b0;
         dwrite_q <= '0;
      end else if (sel_vld) begin
         ptr_q    <= sel_port;
         ack_q    <= 3'b001 << sel_port;
         addr_q   <= sel_addr;
         wr_q     <= sel_we;
         if (sel_we) dwrite_q <= sel_wdata;
      end else begin
         ack_q    <= '0;
         wr_q     <= 1'b0;
      end
   end

   // Tag pipeline lines each read result up with the port that issued it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tag1_vld_q  <= 1'b0;
         tag1_port_q <= 2'd0;
         tag2_vld_q  <= 1'b0;
         tag2_port_q <= 2'd0;
      end else begin
         tag1_vld_q  <= sel_vld & ~sel_we;
         tag1_port_q <= sel_port;
         tag2_vld_q  <= tag1_vld_q;
         tag2_port_q <= tag1_port_q;
      end
   end

   assign bus.ack0            = ack_q[0];
   assign bus.ack1            = ack_q[1];
   assign bus.ack2            = ack_q[2];
   assign bus.rvalid0         = tag2_vld_q && (tag2_port_q == 2'd0);
   assign bus.rvalid1         = tag2_vld_q && (tag2_port_q == 2'd1);
   assign bus.rvalid2         = tag2_vld_q && (tag2_port_q == 2'd2);
   assign bus.rdata           = bus.bRAM_map_data;
   assign bus.lock_err        = lock_err_q;
   assign bus.bRAM_map_addr   = addr_q;
   assign bus.bRAM_map_wr     = wr_q;
   assign bus.bRAM_map_dwrite = dwrite_q;
   assign dbg_lock_state_o    = state_q;
endmodule

// File: tb/tb_map_ram_arbiter.sv
// Directed bench for map_ram_arbiter: write-first bRAM model preloaded with
// 0x1000+addr, hand-computed expectations for each scenario.
module tb_map_ram_arbiter;
   logic clk;
   logic rstn;
   logic dbg;
   int   n_checks;
   int   n_fail;

   map_ram_arbiter_if #(.ADDR_W(19), .DATA_W(16)) bus ();

   map_ram_arbiter #(.ADDR_W(19), .DATA_W(16), .LOCK_TIMEOUT(16)) dut (
      .clk              (clk),
      .rstn             (rstn),
      .bus              (bus),
      .dbg_lock_state_o (dbg)
   );

   logic [2:0] acks;
   logic [2:0] rvs;
   assign acks = {bus.ack2, bus.ack1, bus.ack0};
   assign rvs  = {bus.rvalid2, bus.rvalid1, bus.rvalid0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] mem [0:255];
   always @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'(16'h1000 + i);
      end else if (bus.bRAM_map_wr) begin
         mem[bus.bRAM_map_addr[7:0]] <= bus.bRAM_map_dwrite;
         bus.bRAM_map_data           <= bus.bRAM_map_dwrite;
      end else begin
         bus.bRAM_map_data <= mem[bus.bRAM_map_addr[7:0]];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic drop_reqs();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.req2 = 1'b0;
   endtask

   // Presents one command, waits (bounded) for its ack, then withdraws the request.
   task automatic issue(input int port, input logic we, input logic [18:0] addr,
                        input logic [15:0] wd, input logic lk);
      int n;
      case (port)
         0: begin bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd; end
         1: begin bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd; bus.lock1 = lk; end
         default: begin bus.req2 = 1'b1; bus.we2 = we; bus.addr2 = addr; end
      endcase
      n = 0;
      do begin
         tick();
         n++;
      end while (acks[port] == 1'b0 && n < 10);
      check("issue_ack", 32'(acks[port]), 32'd1);
      drop_reqs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int idx;
      logic seen;
      logic early;
      n_checks = 0;
      n_fail   = 0;
      rstn = 1'b0;
      bus.req0 = 0; bus.req1 = 0; bus.req2 = 0;
      bus.we0 = 0; bus.we1 = 0; bus.we2 = 0;
      bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
      bus.wdata0 = '0; bus.wdata1 = '0; bus.lock1 = 0;
      repeat (2) tick();

      check("rst_ack",      32'(acks), 32'd0);
      check("rst_rvalid",   32'(rvs), 32'd0);
      check("rst_lock_err", 32'(bus.lock_err), 32'd0);
      check("rst_wr",       32'(bus.bRAM_map_wr), 32'd0);
      check("rst_addr",     32'(bus.bRAM_map_addr), 32'd0);
      check("rst_dwrite",   32'(bus.bRAM_map_dwrite), 32'd0);
      check("rst_state",    32'(dbg), 32'd0);
      rstn = 1'b1;
      tick();

      // Contention: all three reading, expect strict 0,1,2 rotation.
      bus.req0 = 1; bus.addr0 = 19'h10;
      bus.req1 = 1; bus.addr1 = 19'h20;
      bus.req2 = 1; bus.addr2 = 19'h30;
      for (int k = 1; k <= 6; k++) begin
         tick();
         check("cont_ack", 32'(acks), 32'd1 << ((k - 1) % 3));
         check("cont_wr", 32'(bus.bRAM_map_wr), 32'd0);
         if (k >= 2) begin
            check("cont_rvalid", 32'(rvs), 32'd1 << ((k - 2) % 3));
            check("cont_rdata", 32'(bus.rdata), 32'h1000 + 32'h10 * (((k - 2) % 3) + 1));
         end
      end
      drop_reqs();
      repeat (3) tick();

      // Read-modify-write under lock with port 2 waiting.
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 19'h45; bus.lock1 = 1;
      tick();
      check("rmw_rd_ack", 32'(acks), 32'b010);
      bus.req2 = 1; bus.we2 = 0; bus.addr2 = 19'h45;
      bus.we1 = 1; bus.wdata1 = 16'h0003; bus.lock1 = 0;
      tick();
      check("rmw_blocked_ack", 32'(acks), 32'd0);
      check("rmw_locked", 32'(dbg), 32'd1);
      check("rmw_rvalid1", 32'(rvs), 32'b010);
      check("rmw_rdata_old", 32'(bus.rdata), 32'h1045);
      tick();
      check("rmw_wr_ack", 32'(acks), 32'b010);
      check("rmw_wr", 32'(bus.bRAM_map_wr), 32'd1);
      check("rmw_dwrite", 32'(bus.bRAM_map_dwrite), 32'h0003);
      bus.req1 = 0; bus.we1 = 0;
      tick();
      check("rmw_ack2", 32'(acks), 32'b100);
      check("rmw_unlocked", 32'(dbg), 32'd0);
      bus.req2 = 0;
      tick();
      check("rmw_rvalid2", 32'(rvs), 32'b100);
      check("rmw_rdata_new", 32'(bus.rdata), 32'h0003);
      repeat (2) tick();

      // Lock timeout with port 0 waiting.
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 19'h50; bus.lock1 = 1;
      tick();
      check("to_lock_ack", 32'(acks), 32'b010);
      check("to_locked", 32'(dbg), 32'd1);
      bus.req1 = 0; bus.lock1 = 0;
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 19'h11;
      n = 0; seen = 0; early = 0;
      while (!seen && n < 40) begin
         tick();
         n++;
         if (bus.lock_err) seen = 1;
         else if (bus.ack0) early = 1;
      end
      check("to_seen", 32'(seen), 32'd1);
      check("to_cycles", 32'(n), 32'd16);
      check("to_no_early_ack0", 32'(early), 32'd0);
      check("to_state", 32'(dbg), 32'd0);
      check("to_ack_at_err", 32'(acks), 32'd0);
      tick();
      check("to_ack0", 32'(acks), 32'b001);
      check("to_err_once", 32'(bus.lock_err), 32'd0);
      drop_reqs();
      repeat (3) tick();

      // Port 0 writes; port 2 write attempt must go out as a read.
      for (int i = 0; i < 8; i++) begin
         issue(0, 1'b1, 19'(i), 16'(16'hD000 + i), 1'b0);
         check("wb_wr", 32'(bus.bRAM_map_wr), 32'd1);
         check("wb_dwrite", 32'(bus.bRAM_map_dwrite), 32'hD000 + 32'(i));
      end
      tick();
      issue(2, 1'b1, 19'h3, 16'h0, 1'b0);
      check("wb_p2_wr", 32'(bus.bRAM_map_wr), 32'd0);
      check("wb_p2_dwrite_held", 32'(bus.bRAM_map_dwrite), 32'hD007);
      bus.we2 = 0;
      tick();
      check("wb_p2_rvalid", 32'(rvs), 32'b100);
      check("wb_p2_rdata", 32'(bus.rdata), 32'hD003);
      for (int i = 0; i < 8; i++) begin
         issue(2, 1'b0, 19'(i), 16'h0, 1'b0);
         tick();
         check("wb_rd_rvalid", 32'(bus.rvalid2), 32'd1);
         check("wb_rd_data", 32'(bus.rdata), 32'hD000 + 32'(i));
      end
      repeat (2) tick();

      // Back-to-back requester on port 2 alone.
      bus.req2 = 1; bus.we2 = 0; bus.addr2 = 19'h60;
      idx = 0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check("b2b_ack2", 32'(bus.ack2), 32'(k % 2));
         check("b2b_rvalid2", 32'(bus.rvalid2), 32'((k + 1) % 2));
         if (k % 2 == 0) check("b2b_rdata", 32'(bus.rdata), 32'h1060 + 32'(k / 2 - 1));
         if (bus.ack2) begin
            idx++;
            if (idx < 4) bus.addr2 = 19'(19'h60 + idx);
            else         bus.req2 = 0;
         end
      end
      repeat (2) tick();

      // Reset while a read is in flight.
      bus.req2 = 1; bus.addr2 = 19'h30;
      tick();
      check("mr_ack2", 32'(acks), 32'b100);
      bus.req2 = 0;
      #1 rstn = 1'b0;
      #1;
      check("mr_ack", 32'(acks), 32'd0);
      check("mr_rvalid", 32'(rvs), 32'd0);
      check("mr_wr", 32'(bus.bRAM_map_wr), 32'd0);
      check("mr_addr", 32'(bus.bRAM_map_addr), 32'd0);
      check("mr_dwrite", 32'(bus.bRAM_map_dwrite), 32'd0);
      check("mr_state", 32'(dbg), 32'd0);
      tick();
      rstn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("mr_no_rvalid", 32'(rvs), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/map_ram_arbiter.md
# map_ram_arbiter

Three-port arbiter sharing the single map bRAM port among the level loader (port 0, writes), the interaction unit (port 1, read-modify-write) and the tile renderer (port 2, reads). It issues at most one access per cycle using round-robin selection. It gives port 1 an exclusive lock so that a tile read and its write-back cannot be split by another requester. All bRAM control outputs are registered; read data returns to the owning port with a fixed latency.

## Interface
- `ADDR_W`, 19, map bRAM address width
- `DATA_W`, 16, tile word width
- `LOCK_TIMEOUT`, 16, idle cycles after which a held port-1 lock is forcibly dropped (≥2)
- `clk`  in  1  system clock; all logic on rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `req0`/`req1`/`req2`  in  1  access request, held until that port's ack
- `we0`/`we1`/`we2`  in  1  1 = write, 0 = read (`we2` tied 0 by renderer; treated as read regardless)
- `addr0`/`addr1`/`addr2`  in  ADDR_W  access address
- `wdata0`/`wdata1`  in  DATA_W  write data
- `lock1`  in  1  port-1 lock request, sampled with each port-1 grant
- `ack0`/`ack1`/`ack2`  out  1  one-cycle pulse: command issued to bRAM
- `rvalid0`/`rvalid1`/`rvalid2`  out  1  one-cycle pulse: `rdata` holds this port's read result
- `rdata`  out  DATA_W  read data, a combinational pass-through of `bRAM_map_data`
- `lock_err`  out  1  one-cycle pulse when the lock is dropped by timeout
- `bRAM_map_addr`  out  ADDR_W  bRAM address, registered
- `bRAM_map_wr`  out  1  bRAM write strobe, registered
- `bRAM_map_dwrite`  out  DATA_W  bRAM write data, registered
- `bRAM_map_data`  in  DATA_W  bRAM read data, valid one cycle after the address is presented

## Operation
- **Arbitration (cycle G).**
  - If not locked: choose among asserted `req` using round-robin order starting at (last granted port + 1) mod 3.
  - The pointer resets to 2, so the first order is 0, 1, 2.
  - If locked: only port 1 is eligible. Requests on ports 0 and 2 wait with their `ack` low.
- **Issue (edge ending G).**
  - Register `bRAM_map_addr` ← addrN.
  - Register `bRAM_map_wr` ← weN (forced 0 for port 2).
  - Register `bRAM_map_dwrite` ← wdataN for a write; otherwise hold the previous value.
  - Register `ackN` = 1 for exactly one cycle and update the pointer to N.
  - With no eligible request: `bRAM_map_wr` ← 0, all acks 0, address held.
- **Requester rule.**
  - A requester seeing `ackN` in a cycle may present its next command in that same cycle.
  - The arbiter does not re-grant a port in the cycle its ack is high. This gives each port a maximum of one access per 2 cycles.
  - The bus as a whole sustains one access per cycle.
- **Read return.**
  - A 2-stage tag pipeline {valid, port}, cleared by reset, tracks each read.
  - `rvalidN` pulses 2 cycles after G, i.e. one cycle after the address is on the bus.
  - Writes produce no `rvalid`.
- **Lock FSM: states UNLOCKED, LOCKED.**
  - UNLOCKED → LOCKED: port 1 is granted with `lock1` = 1.
  - LOCKED → UNLOCKED:
    - port 1 is granted with `lock1` = 0 (that access is still exclusive), or
    - the idle counter reaches LOCK_TIMEOUT; `lock_err` pulses in the cycle the FSM returns to UNLOCKED.
  - Idle counter:
    - counts cycles in LOCKED with `req1` = 0;
    - clears on any port-1 grant;
    - saturates at LOCK_TIMEOUT.
- **Write-then-read, same address.** Order is preserved because there is a single issue point. A read issued the cycle after a write returns the new data, following the bRAM write-first behaviour.

## Timing
- **Reset values:**
  - all `ack`, `rvalid`, `lock_err` = 0;
  - `bRAM_map_wr` = 0, `bRAM_map_addr` = 0, `bRAM_map_dwrite` = 0;
  - FSM = UNLOCKED, pointer = 2, counter = 0.
- **Reset mid-operation:** in-flight reads are discarded; no `rvalid` appears after `rstn` rises.
- **Latency:** request seen in cycle G → ack in G+1 → read data (`rvalid`) in G+2.
- **Simultaneous requests:** all three asserted continuously from reset gives grants 0, 1, 2, 0, 1, 2…; each port waits at most 2 cycles while unlocked.
- **Lock release and grant:** a lock release and a port-0/2 grant never occur in the same cycle. The first non-port-1 grant is in the cycle after the FSM returns to UNLOCKED.

## Test plan
- **Reset:** assert `rstn` = 0 mid-read → all outputs at the reset values above, no stray `rvalid` after release.
- **Contention:** `req0`/`req1`/`req2` all held high as reads to addresses 0x10/0x20/0x30 → acks rotate 0, 1, 2; `rvalid` order 0, 1, 2; each `rdata` matches the preloaded memory; `bRAM_map_wr` stays 0.
- **Read-modify-write:**
  1. Port 1 reads 0x45 with `lock1` = 1 while `req2` is held.
  2. `ack2` stays low; port 1 writes 0x0003 to 0x45 with `lock1` = 0.
  3. The next cycle grants port 2; a port-2 read of 0x45 returns 0x0003.
- **Lock timeout:**
  1. Port 1 locks, then deasserts `req1` for 16 cycles while `req0` is high.
  2. `lock_err` pulses once; `ack0` follows on the next cycle; FSM is UNLOCKED.
- **Write blocking:** port 0 writes 0x0000…0x0007; port 2 `we2` = 1 with a request → port-2 access is issued as a read (`bRAM_map_wr` = 0); memory holds the port-0 values.
- **Back-to-back requester:** port 2 alone issues new reads in each ack cycle → `ack2` is high every other cycle and `rvalid2` follows each ack by 1 cycle.
